// File: rtl/us_delay_arbiter.sv
// us_delay_arbiter: round-robin share of one us down-counter among N_REQ requesters.
// Ports: clk, rst_n, clk_1MHz, req, dly_us -> grant, done, busy, cur_cnt. Option: US_ARB_ABORT_EN.
module us_delay_arbiter #(
  parameter int N_REQ = 4,
  parameter int DLY_W = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   clk_1MHz,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ*DLY_W-1:0] dly_us,
  output logic [N_REQ-1:0]       grant,
  output logic [N_REQ-1:0]       done,
  output logic                   busy,
  output logic [DLY_W-1:0]       cur_cnt
);

  localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] COUNT = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  logic [1:0]       state;
  logic [PW-1:0]    rr_ptr;
  logic [PW-1:0]    w_q;
  logic [N_REQ-1:0] served;
  logic [DLY_W-1:0] cnt;
  logic             clk_1MHz_d;

  logic             tick;
  logic             abort;
  logic [N_REQ-1:0] elig;
  logic             found;
  logic [PW-1:0]    win;
  logic [PW:0]      idx;
  logic [N_REQ-1:0] win_oh;
  logic [DLY_W-1:0] win_dly;
  logic [PW-1:0]    w_next;

  assign tick    = clk_1MHz & ~clk_1MHz_d;
  assign elig    = req & ~served;
  assign busy    = (state != IDLE);
  assign cur_cnt = cnt;

`ifdef US_ARB_ABORT_EN
  assign abort = (state == COUNT) & ~req[w_q];
`else
  assign abort = 1'b0;
`endif

  // Rotating priority search starting at rr_ptr.
  always_comb begin
    found = 1'b0;
    win   = '0;
    idx   = '0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = {1'b0, rr_ptr} + (PW+1)'(k);
      if (idx >= (PW+1)'(N_REQ))
        idx = idx - (PW+1)'(N_REQ);
      if (!found && elig[idx[PW-1:0]]) begin
        found = 1'b1;
        win   = idx[PW-1:0];
      end
    end
  end

  always_comb begin
    win_oh      = '0;
    win_oh[win] = 1'b1;
  end

  assign win_dly = dly_us[int'(win)*DLY_W +: DLY_W];
  assign w_next  = (w_q == PW'(N_REQ-1)) ? '0 : w_q + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      rr_ptr     <= '0;
      w_q        <= '0;
      served     <= '0;
      cnt        <= '0;
      clk_1MHz_d <= 1'b0;
      grant      <= '0;
      done       <= '0;
    end else begin
      clk_1MHz_d <= clk_1MHz;
      served     <= served & req;
      done       <= '0;
      unique case (state)
        IDLE: begin
          if (found) begin
            grant <= win_oh;
            w_q   <= win;
            cnt   <= win_dly;
            if (win_dly == '0) begin
              state <= DONE;
              done  <= win_oh;
            end else begin
              state <= COUNT;
            end
          end
        end
        COUNT: begin
          // An abort wins over a terminal tick in the same cycle.
          if (abort) begin
            grant  <= '0;
            cnt    <= '0;
            state  <= IDLE;
            rr_ptr <= w_next;
          end else if (tick) begin
            if (cnt > DLY_W'(1)) begin
              cnt <= cnt - 1'b1;
            end else begin
              cnt   <= '0;
              state <= DONE;
              done  <= grant;
            end
          end
        end
        DONE: begin
          grant  <= '0;
          state  <= IDLE;
          served <= (served & req) | grant;
          rr_ptr <= w_next;
        end
        default: begin
          grant <= '0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_us_delay_arbiter.sv
// tb_us_delay_arbiter: directed bench with a grant-order scoreboard.
// Drives requests and a 1 MHz timebase, checks grants, done pulses and timing.
module tb_us_delay_arbiter;

  localparam int N = 4;
  localparam int W = 16;

  logic           clk;
  logic           rst_n;
  logic           clk_1MHz;
  logic [N-1:0]   req;
  logic [N*W-1:0] dly_us;
  logic [N-1:0]   grant;
  logic [N-1:0]   done;
  logic           busy;
  logic [W-1:0]   cur_cnt;

  int errors = 0;
  int checks = 0;
  int sb[$];

  us_delay_arbiter #(.N_REQ(N), .DLY_W(W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .clk_1MHz (clk_1MHz),
    .req      (req),
    .dly_us   (dly_us),
    .grant    (grant),
    .done     (done),
    .busy     (busy),
    .cur_cnt  (cur_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // 1 us period, edges kept clear of clk edges.
  initial begin
    clk_1MHz = 1'b0;
    #3;
    forever #500 clk_1MHz = ~clk_1MHz;
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic set_dly(input int i, input logic [W-1:0] v);
    dly_us[i*W +: W] = v;
  endtask

  task automatic wait_grant(input int lim, output int n);
    n = -1;
    for (int i = 1; i <= lim; i++) begin
      @(negedge clk);
      if (grant != '0) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic wait_done(input int lim, output int n);
    n = -1;
    for (int i = 1; i <= lim; i++) begin
      @(negedge clk);
      if (done != '0) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic pop_grant(input string tag);
    int e;
    if (sb.size() == 0) begin
      chk({tag, "_sb"}, 32'(grant), 32'hdead);
    end else begin
      e = sb.pop_front();
      chk(tag, 32'(grant), 32'(1 << e));
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_g"}, 32'(grant), 32'h0);
    chk({tag, "_d"}, 32'(done), 32'h0);
    chk({tag, "_b"}, 32'(busy), 32'h0);
    chk({tag, "_c"}, 32'(cur_cnt), 32'h0);
  endtask

  initial begin
    int n;
    int n2;
    int cntg;
    int exp_i;

    rst_n  = 1'b0;
    req    = '0;
    dly_us = '0;
    step(3);
    chk_idle("rst");
    rst_n = 1'b1;
    step(2);

    // 1: single request, 5 us
    set_dly(0, 16'd5);
    req = 4'b0001;
    sb.push_back(0);
    step(1);
    pop_grant("t1_grant");
    chk("t1_cnt", 32'(cur_cnt), 32'd5);
    wait_done(700, n);
    chk("t1_lat", 32'(n >= 401 && n <= 500), 32'd1);
    chk("t1_done", 32'(done), 32'b0001);
    chk("t1_gdone", 32'(grant), 32'b0001);
    step(1);
    chk("t1_dclr", 32'(done), 32'h0);
    chk("t1_gclr", 32'(grant), 32'h0);
    chk("t1_busy", 32'(busy), 32'h0);
    step(3);
    chk("t1_noreg", 32'(grant), 32'h0);
    req = '0;
    step(2);

    // 2: zero delay, grant and done together
    set_dly(2, 16'd0);
    req = 4'b0100;
    sb.push_back(2);
    step(1);
    pop_grant("t2_grant");
    chk("t2_done", 32'(done), 32'b0100);
    chk("t2_busy", 32'(busy), 32'd1);
    step(1);
    chk("t2_gclr", 32'(grant), 32'h0);
    chk("t2_dclr", 32'(done), 32'h0);
    chk("t2_bclr", 32'(busy), 32'h0);
    req = '0;
    step(2);

    // 3: all four held, dly=2, from a fresh pointer
    rst_n = 1'b0;
    step(1);
    chk_idle("t3_rst");
    rst_n = 1'b1;
    step(1);
    for (int i = 0; i < N; i++) set_dly(i, 16'd2);
    req = 4'b1111;
    for (int i = 0; i < N; i++) sb.push_back(i);
    for (int i = 0; i < N; i++) begin
      exp_i = sb[0];
      wait_grant(10, n);
      chk("t3_gto", 32'(n > 0), 32'd1);
      pop_grant("t3_grant");
      wait_done(400, n);
      chk("t3_dto", 32'(n > 0), 32'd1);
      chk("t3_done", 32'(done), 32'(1 << exp_i));
    end
    cntg = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (grant != '0 || done != '0) cntg++;
    end
    chk("t3_no5th", 32'(cntg), 32'd0);
    req = '0;
    step(2);

    // 4: serve 1, then 0 and 2 together -> 2 first
    for (int i = 0; i < N; i++) set_dly(i, 16'd1);
    req = 4'b0010;
    sb.push_back(1);
    wait_grant(10, n);
    pop_grant("t4_g1");
    wait_done(300, n);
    chk("t4_d1", 32'(done), 32'b0010);
    req = '0;
    step(2);
    req = 4'b0101;
    sb.push_back(2);
    sb.push_back(0);
    wait_grant(10, n);
    pop_grant("t4_g2");
    wait_done(300, n);
    chk("t4_d2", 32'(done), 32'b0100);
    wait_grant(10, n);
    pop_grant("t4_g0");
    wait_done(300, n);
    chk("t4_d0", 32'(done), 32'b0001);
    req = '0;
    step(2);

    // 5: drop req1 after ~3 ticks of a 10 us delay
    set_dly(1, 16'd10);
    req = 4'b0010;
    sb.push_back(1);
    wait_grant(10, n);
    pop_grant("t5_grant");
    step(300);
    chk("t5_mid", 32'(cur_cnt >= 16'd7 && cur_cnt <= 16'd8), 32'd1);
    req = '0;
    step(1);
`ifdef US_ARB_ABORT_EN
    chk("t5_abort_g", 32'(grant), 32'h0);
    chk("t5_abort_b", 32'(busy), 32'h0);
    wait_done(800, n);
    chk("t5_nodone", 32'(n), 32'hffffffff);
`else
    chk("t5_held", 32'(grant), 32'b0010);
    wait_done(800, n2);
    chk("t5_lat", 32'(n2 > 0 && (301 + n2) >= 901 && (301 + n2) <= 1000),
        32'd1);
    chk("t5_done", 32'(done), 32'b0010);
`endif
    step(2);

    // 6: async reset mid-count, then pointer restarts at 0
    set_dly(0, 16'd8);
    req = 4'b0001;
    sb.push_back(0);
    wait_grant(10, n);
    pop_grant("t6_grant");
    step(250);
    chk("t6_mid", 32'(cur_cnt >= 16'd5 && cur_cnt <= 16'd6), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk_idle("t6_async");
    req = '0;
    step(2);
    rst_n = 1'b1;
    step(1);
    set_dly(1, 16'd3);
    set_dly(3, 16'd3);
    req = 4'b1010;
    sb.push_back(1);
    wait_grant(10, n);
    pop_grant("t6_rr0");
    wait_done(500, n);
    chk("t6_done", 32'(done), 32'b0010);
    req = '0;
    step(2);

    // all-ones delay is accepted and counts down without wrapping
    set_dly(3, 16'hffff);
    req = 4'b1000;
    sb.push_back(3);
    wait_grant(10, n);
    pop_grant("t7_grant");
    chk("t7_cnt", 32'(cur_cnt), 32'hffff);
    step(150);
    chk("t7_dec", 32'(cur_cnt >= 16'hfffd && cur_cnt <= 16'hfffe), 32'd1);
    rst_n = 1'b0;
    step(1);
    chk_idle("t7_rst");
    chk("sb_empty", 32'(sb.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
